// File: rtl/time_display_driver.sv
// time_display_driver
//   Multiplexed 4-digit 7-segment driver for an MM:SS clock.
//   A refresh counter scans the digits right to left, one digit every
//   REFRESH_DIV cycles. The seconds and minutes values are latched once per
//   scan frame, so all four digits in a frame come from the same pair.
//   Adjust mode blinks the selected field. The decimal point serves as a
//   colon on digit 2, and flashes on every digit for four digit periods
//   after a seconds wrap.
//
// Ports
//   clk      : clock, all state updates on the rising edge
//   rst      : synchronous active-high reset
//   seconds  : binary seconds (0..59; 60..63 shows dashes)
//   minutes  : binary minutes (0..59; 60..63 shows dashes)
//   sec_wrap : one-cycle pulse when the seconds counter wraps 59->0
//   adj_en   : adjust mode enable (blinks the selected field)
//   adj_sel  : field to blink, 0 = minutes, 1 = seconds
//   seg      : active-low segments, seg[0]=a .. seg[6]=g (registered)
//   dp       : active-low decimal point (registered)
//   an       : active-low anodes, an[3]=min tens .. an[0]=sec ones (registered)
module time_display_driver #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] seconds,
  input  logic [5:0] minutes,
  input  logic       sec_wrap,
  input  logic       adj_en,
  input  logic       adj_sel,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an
);

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [RW-1:0] REF_LAST   = RW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  // Active-low segment pattern for one decimal digit.
  function automatic logic [6:0] enc7(input logic [3:0] d);
    case (d)
      4'd0:    enc7 = 7'h40;
      4'd1:    enc7 = 7'h79;
      4'd2:    enc7 = 7'h24;
      4'd3:    enc7 = 7'h30;
      4'd4:    enc7 = 7'h19;
      4'd5:    enc7 = 7'h12;
      4'd6:    enc7 = 7'h02;
      4'd7:    enc7 = 7'h78;
      4'd8:    enc7 = 7'h00;
      4'd9:    enc7 = 7'h10;
      default: enc7 = 7'h7F;
    endcase
  endfunction

  // Tens or ones digit of a 0..63 value; out-of-range values show a dash.
  function automatic logic [6:0] digit_seg(input logic [5:0] v, input logic tens);
    logic [3:0] t;
    logic [3:0] o;
    t = 4'(v / 6'd10);
    o = 4'(v % 6'd10);
    if (v >= 6'd60) return 7'h3F;
    return enc7(tens ? t : o);
  endfunction

  logic [RW-1:0] refresh_cnt;
  logic [1:0]    digit_idx;
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;
  logic          colon_phase;
  logic [2:0]    flash_cnt;
  logic [5:0]    sec_lat;
  logic [5:0]    min_lat;

  logic          advance;
  logic          frame_end;
  logic [5:0]    field_val;
  logic          blanked;
  logic [6:0]    seg_p0;
  logic [3:0]    an_p0;
  logic          dp_p0;

  assign advance   = (refresh_cnt == REF_LAST);
  assign frame_end = advance && (digit_idx == 2'd3);

  // ---- stage p0: decode current scan state into the next display word ----
  always_comb begin
    field_val = digit_idx[1] ? min_lat : sec_lat;
    seg_p0    = digit_seg(field_val, digit_idx[0]);
    an_p0     = ~(4'b0001 << digit_idx);
    // digit_idx[1] is 1 for the minutes digits, adj_sel is 1 for seconds
    blanked   = adj_en && blink_phase && (digit_idx[1] != adj_sel);
    dp_p0     = ~((flash_cnt != 3'd0) || (colon_phase && (digit_idx == 2'd2)));
    if (blanked) begin
      an_p0  = 4'hF;
      seg_p0 = 7'h7F;
      dp_p0  = 1'b1;
    end
  end

  // ---- stage p1: scan/blink/flash state and registered outputs ----
  always_ff @(posedge clk) begin
    if (rst) begin
      refresh_cnt <= '0;
      digit_idx   <= 2'd0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      colon_phase <= 1'b0;
      flash_cnt   <= 3'd0;
      sec_lat     <= 6'd0;
      min_lat     <= 6'd0;
      an          <= 4'hF;
      seg         <= 7'h7F;
      dp          <= 1'b1;
    end else begin
      if (advance) begin
        refresh_cnt <= '0;
        digit_idx   <= digit_idx + 2'd1;
      end else begin
        refresh_cnt <= refresh_cnt + 1'b1;
      end

      if (frame_end) begin
        sec_lat <= seconds;
        min_lat <= minutes;
        if (seconds != sec_lat) colon_phase <= ~colon_phase;
      end

      // Blink starts in the visible half each time adjust mode is entered.
      if (!adj_en) begin
        blink_cnt   <= '0;
        blink_phase <= 1'b0;
      end else if (blink_cnt == BLINK_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end

      // A fresh wrap restarts the flash even on a digit-advance cycle.
      if (sec_wrap) flash_cnt <= 3'd4;
      else if (advance && (flash_cnt != 3'd0)) flash_cnt <= flash_cnt - 3'd1;

      an  <= an_p0;
      seg <= seg_p0;
      dp  <= dp_p0;
    end
  end

endmodule

// File: doc/time_display_driver.md
TIME_DISPLAY_DRIVER -- requirements
Module: time_display_driver

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000, clk cycles each digit is driven before the scan advances.
REQ-002 SHALL have parameter BLINK_DIV, default 25000000, clk cycles per blink half-period in adjust mode.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port seconds  input  6  binary seconds from the upstream mod-60 seconds counter.
REQ-006 SHALL have port minutes  input  6  binary minutes value.
REQ-007 SHALL have port sec_wrap  input  1  one-cycle pulse from the seconds counter when seconds wrap 59->0.
REQ-008 SHALL have port adj_en  input  1  adjust mode enable.
REQ-009 SHALL have port adj_sel  input  1  adjust field select: 0 = minutes, 1 = seconds.
REQ-010 SHALL have port seg  output  7  active-low segments, seg[0]=a ... seg[6]=g.
REQ-011 SHALL have port dp  output  1  active-low decimal point.
REQ-012 SHALL have port an  output  4  active-low anode select; an[3]=min tens, an[2]=min ones, an[1]=sec tens, an[0]=sec ones.

Function
REQ-013 The refresh counter SHALL count 0..REFRESH_DIV-1; at REFRESH_DIV-1 it SHALL wrap to 0 and advance the digit index 0->1->2->3->0.
REQ-014 seg, dp and an SHALL be registered; they SHALL reflect a new digit index one cycle after the terminal refresh count.
REQ-015 Outside blanking, exactly one an bit SHALL be low: an[i] low when digit index = i.
REQ-016 seconds and minutes SHALL be latched only when the index advances 3->0; digits within one scan frame SHALL come from a single latched pair.
REQ-017 Each latched value SHALL be split into tens = v/10 and ones = v%10.
REQ-018 A latched value of 60..63 SHALL display a dash (seg=7'h3F) on both of its digits.
REQ-019 Digit encodings (seg, hex): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
REQ-020 The blink counter SHALL count 0..BLINK_DIV-1 only while adj_en=1 and toggle blink_phase at the terminal count; while adj_en=0 the counter and blink_phase SHALL be held at 0.
REQ-021 While adj_en=1 and blink_phase=1, both anodes of the selected field (adj_sel=0: an[3:2]; adj_sel=1: an[1:0]) SHALL be held high while the scan continues.
REQ-022 On an adj_en 0->1 transition the field SHALL be visible for the first full BLINK_DIV cycles.
REQ-023 A change of adj_sel mid-blink SHALL move blanking to the new field on the next cycle without resetting the blink counter.
REQ-024 colon_phase SHALL toggle on every cycle where the latched seconds value differs from its previous latched value; dp SHALL be low on digit 2 when colon_phase=1.
REQ-025 On sec_wrap=1, flash_cnt SHALL load 4 and decrement by 1 on each digit advance; while flash_cnt!=0, dp SHALL be low on every digit.
REQ-026 If sec_wrap coincides with a digit advance, the load of 4 SHALL take priority over the decrement.
REQ-027 dp on blanked digits SHALL be high.

Reset
REQ-028 While rst=1 at a clock edge, the module SHALL load: refresh counter=0, digit index=0, blink counter=0, blink_phase=0, colon_phase=0, flash_cnt=0, latched values=0, an=4'hF, seg=7'h7F, dp=1.
REQ-029 On the first cycle after rst deasserts, the module SHALL drive digit 0 (an=4'hE) with the latched value 0 (seg=7'h40).
REQ-030 rst asserted mid-scan or mid-blink SHALL abandon the current state with no residual blanking or flash.

Verification (REFRESH_DIV=4, BLINK_DIV=16)
REQ-031 With seconds=37 and minutes=12 after one full frame, the bench SHALL see an sequence E,D,B,7 with seg 78,30,24,79, each held 4 cycles.
REQ-032 When seconds changes 37->38 mid-frame, the bench SHALL see the new digits only after the next 3->0 advance.
REQ-033 With seconds=61, the bench SHALL see seg=3F on an=E and an=D.
REQ-034 With adj_en=1 and adj_sel=1, the bench SHALL see an[1:0] never low during cycles 16-31 after adj_en rises and normal operation during cycles 0-15; minutes digits SHALL be unaffected.
REQ-035 A sec_wrap pulse SHALL cause dp=0 for the next 4 digit periods on every digit, and the load SHALL win when the pulse coincides with a digit advance.
REQ-036 rst asserted during a blink-off phase SHALL give an=F the next cycle, then an=E and seg=40 after release.
